memory_access: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; consumes the execute-stage outputs (ALU result, store data, MEM/WB controls, destination register).
- Holds a byte-addressable, little-endian data memory.
- Performs LB/LBU/LH/LHU/LW/LWU loads and SB/SH/SW stores.
- Registers load data, ALU result and WB controls into the MEM/WB pipeline register for write-back; o_ALU_result also feeds the execute-stage forwarding path.

---
 rtl/memory_access.sv | 114 +++++++++++
 tb/tb_memory_access.sv | 124 ++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage MIPS pipeline with byte-addressable little-endian data memory
//
// Loads (LB/LBU/LH/LHU/LW/LWU) and stores (SB/SH/SW) against a 2^MEM_ADDR_WIDTH byte
// memory, followed by the MEM/WB pipeline register.
//
// Ports:
//   i_clk                  clock, all state updates on posedge
//   i_reset                synchronous active-high reset (outputs to 0, memory kept)
//   i_halt                 pipeline freeze: outputs hold, stores suppressed
//   i_WB_write             register-file write enable, passed to WB
//   i_WB_mem_to_reg        WB source select (1 memory, 0 ALU), passed to WB
//   i_MEM_read             load enable
//   i_MEM_write            store enable
//   i_MEM_unsigned         1 zero-extends, 0 sign-extends byte/half loads
//   i_MEM_byte_half_word   access size: 00 byte, 01 half, 1x word
//   i_write_reg            destination register
//   i_data_to_write_in_MEM store data
//   i_ALU_result           effective address / ALU value
//   o_WB_write, o_WB_mem_to_reg, o_write_reg, o_mem_data, o_ALU_result
//                          MEM/WB register outputs
//
// Optional: define MEM_DEBUG_PORT_EN to add i_debug_addr (word index) and
// o_debug_data, a combinational word read for the debug unit.
module memory_access #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_halt,
   input  logic                      i_WB_write,
   input  logic                      i_WB_mem_to_reg,
   input  logic                      i_MEM_read,
   input  logic                      i_MEM_write,
   input  logic                      i_MEM_unsigned,
   input  logic [1:0]                i_MEM_byte_half_word,
   input  logic [4:0]                i_write_reg,
   input  logic [DATA_WIDTH-1:0]     i_data_to_write_in_MEM,
   input  logic [DATA_WIDTH-1:0]     i_ALU_result,
`ifdef MEM_DEBUG_PORT_EN
   input  logic [MEM_ADDR_WIDTH-3:0] i_debug_addr,
   output logic [DATA_WIDTH-1:0]     o_debug_data,
`endif
   output logic                      o_WB_write,
   output logic                      o_WB_mem_to_reg,
   output logic [4:0]                o_write_reg,
   output logic [DATA_WIDTH-1:0]     o_mem_data,
   output logic [DATA_WIDTH-1:0]     o_ALU_result
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int WORDS = 2 ** (MEM_ADDR_WIDTH - 2);

   logic [DATA_WIDTH-1:0]     mem [0:WORDS-1];
   logic [MEM_ADDR_WIDTH-1:0] addr;
   logic [MEM_ADDR_WIDTH-3:0] word_idx;
   logic [DATA_WIDTH-1:0]     rd_word;
   logic [7:0]                rd_byte;
   logic [15:0]               rd_half;
   logic [DATA_WIDTH-1:0]     load_data;
   logic [DATA_WIDTH-1:0]     wr_data;
   logic [LANES-1:0]          byte_en;
   logic                      sext;

   // Upper address bits are dropped, so accesses wrap modulo the memory size.
   // Half/word alignment is forced by simply ignoring the low lane bits.
   always_comb begin
      addr      = i_ALU_result[MEM_ADDR_WIDTH-1:0];
      word_idx  = addr[MEM_ADDR_WIDTH-1:2];
      rd_word   = mem[word_idx];
      rd_byte   = rd_word[{addr[1:0], 3'b000} +: 8];
      rd_half   = addr[1] ? rd_word[16 +: 16] : rd_word[0 +: 16];
      sext      = ~i_MEM_unsigned;
      load_data = i_MEM_byte_half_word == 2'b00 ? {{(DATA_WIDTH-8){sext & rd_byte[7]}}, rd_byte} :
                  i_MEM_byte_half_word == 2'b01 ? {{(DATA_WIDTH-16){sext & rd_half[15]}}, rd_half} :
                  rd_word;
      // Store data is replicated across lanes; byte_en picks which lanes land.
      wr_data   = i_MEM_byte_half_word == 2'b00 ? {LANES{i_data_to_write_in_MEM[7:0]}} :
                  i_MEM_byte_half_word == 2'b01 ? {(LANES/2){i_data_to_write_in_MEM[15:0]}} :
                  i_data_to_write_in_MEM;
      byte_en   = i_MEM_byte_half_word == 2'b00 ? LANES'(1) << addr[1:0] :
                  i_MEM_byte_half_word == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) :
                  {LANES{1'b1}};
   end

   // Memory is never cleared; reset and halt only block the write.
   always_ff @(posedge i_clk)
      if (!i_reset && !i_halt && i_MEM_write)
         for (int k = 0; k < LANES; k++)
            if (byte_en[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];

   // MEM/WB register; the load path reads pre-write contents (read-before-write).
   always_ff @(posedge i_clk)
      if (i_reset) begin
         o_WB_write      <= 1'b0;
         o_WB_mem_to_reg <= 1'b0;
         o_write_reg     <= '0;
         o_mem_data      <= '0;
         o_ALU_result    <= '0;
      end else if (!i_halt) begin
         o_WB_write      <= i_WB_write;
         o_WB_mem_to_reg <= i_WB_mem_to_reg;
         o_write_reg     <= i_write_reg;
         o_mem_data      <= i_MEM_read ? load_data : '0;
         o_ALU_result    <= i_ALU_result;
      end

`ifdef MEM_DEBUG_PORT_EN
   assign o_debug_data = mem[i_debug_addr];
`else
   // No debug read path in the default build.
`endif

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed scoreboard bench for the MEM stage
module tb_memory_access;

   logic        clk = 1'b0;
   logic        reset, halt, wb_write, mem_to_reg, mem_read, mem_write, mem_unsigned;
   logic [1:0]  size;
   logic [4:0]  write_reg;
   logic [31:0] store_data, alu_in;
   logic        o_wb_write, o_mem_to_reg;
   logic [4:0]  o_wreg;
   logic [31:0] o_mem_data, o_alu;

   typedef struct packed {
      logic [7:0]  id;
      logic        wbw;
      logic        m2r;
      logic [4:0]  wr;
      logic [31:0] md;
      logic [31:0] alu;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   memory_access dut (
      .i_clk                  (clk),
      .i_reset                (reset),
      .i_halt                 (halt),
      .i_WB_write             (wb_write),
      .i_WB_mem_to_reg        (mem_to_reg),
      .i_MEM_read             (mem_read),
      .i_MEM_write            (mem_write),
      .i_MEM_unsigned         (mem_unsigned),
      .i_MEM_byte_half_word   (size),
      .i_write_reg            (write_reg),
      .i_data_to_write_in_MEM (store_data),
      .i_ALU_result           (alu_in),
      .o_WB_write             (o_wb_write),
      .o_WB_mem_to_reg        (o_mem_to_reg),
      .o_write_reg            (o_wreg),
      .o_mem_data             (o_mem_data),
      .o_ALU_result           (o_alu)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
      end
   endtask

   // Monitor: every posedge produces one MEM/WB output set; compare it half a cycle later.
   always @(negedge clk)
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("wb_write",   e.id, {31'b0, o_wb_write},   {31'b0, e.wbw});
         chk("mem_to_reg", e.id, {31'b0, o_mem_to_reg}, {31'b0, e.m2r});
         chk("write_reg",  e.id, {27'b0, o_wreg},       {27'b0, e.wr});
         chk("mem_data",   e.id, o_mem_data,            e.md);
         chk("alu_result", e.id, o_alu,                 e.alu);
      end

   task automatic step(input int id, input logic rst, hlt, wbw, m2r, rd, wr, uns,
                       input logic [1:0] sz, input logic [4:0] wreg,
                       input logic [31:0] data, alu,
                       input logic ewbw, em2r, input logic [4:0] ewr,
                       input logic [31:0] emd, ealu);
      exp_t e;
      @(negedge clk);
      reset = rst; halt = hlt; wb_write = wbw; mem_to_reg = m2r;
      mem_read = rd; mem_write = wr; mem_unsigned = uns; size = sz;
      write_reg = wreg; store_data = data; alu_in = alu;
      @(posedge clk);
      e = '{id: 8'(id), wbw: ewbw, m2r: em2r, wr: ewr, md: emd, alu: ealu};
      q.push_back(e);
   endtask

   initial begin
      //    id rst hlt wbw m2r rd wr uns sz     wreg data          alu        | wbw m2r wr  mem_data      alu
      step( 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0,  32'h0,        32'd0,         0, 0, 0,  32'h0,        32'd0);
      step( 1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0,  32'h8899AABB, 32'd8,         0, 0, 0,  32'h0,        32'd8);
      step( 2, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0,  32'h11223344, 32'd4,         0, 0, 0,  32'h0,        32'd4);
      step( 3, 0, 0, 1, 1, 1, 0, 0, 2'b10, 6,  32'h0,        32'd8,         1, 1, 6,  32'h8899AABB, 32'd8);
      step( 4, 0, 0, 1, 1, 1, 0, 0, 2'b00, 6,  32'h0,        32'd9,         1, 1, 6,  32'hFFFFFFAA, 32'd9);
      step( 5, 0, 0, 1, 1, 1, 0, 1, 2'b00, 6,  32'h0,        32'd9,         1, 1, 6,  32'h000000AA, 32'd9);
      step( 6, 0, 0, 1, 1, 1, 0, 0, 2'b01, 6,  32'h0,        32'd10,        1, 1, 6,  32'hFFFF8899, 32'd10);
      step( 7, 0, 0, 1, 1, 1, 0, 1, 2'b01, 6,  32'h0,        32'd11,        1, 1, 6,  32'h00008899, 32'd11);
      step( 8, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0,  32'h00000012, 32'd11,        0, 0, 0,  32'h0,        32'd11);
      step( 9, 0, 0, 1, 1, 1, 0, 0, 2'b10, 6,  32'h0,        32'd8,         1, 1, 6,  32'h1299AABB, 32'd8);
      step(10, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0,  32'h00003456, 32'd264,       0, 0, 0,  32'h0,        32'd264);
      step(11, 0, 0, 1, 1, 1, 0, 0, 2'b10, 6,  32'h0,        32'd8,         1, 1, 6,  32'h12993456, 32'd8);
      step(12, 0, 0, 1, 1, 1, 0, 0, 2'b00, 6,  32'h0,        32'd8,         1, 1, 6,  32'h00000056, 32'd8);
      step(13, 0, 0, 1, 1, 1, 0, 0, 2'b01, 6,  32'h0,        32'd8,         1, 1, 6,  32'h00003456, 32'd8);
      step(14, 0, 0, 1, 0, 0, 0, 0, 2'b10, 31, 32'h0,        32'h0000000B,  1, 0, 31, 32'h0,        32'h0000000B);
      step(15, 0, 0, 1, 1, 1, 1, 0, 2'b10, 9,  32'h55667788, 32'd4,         1, 1, 9,  32'h11223344, 32'd4);
      step(16, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0,  32'h0BADCAFE, 32'd0,         0, 0, 0,  32'h0,        32'd0);
      step(17, 0, 0, 1, 1, 1, 0, 0, 2'b10, 7,  32'h0,        32'd8,         1, 1, 7,  32'h12993456, 32'd8);
      step(18, 0, 1, 0, 0, 0, 1, 0, 2'b10, 3,  32'hDEADBEEF, 32'd0,         1, 1, 7,  32'h12993456, 32'd8);
      step(19, 0, 1, 0, 0, 0, 1, 0, 2'b10, 3,  32'hDEADBEEF, 32'd0,         1, 1, 7,  32'h12993456, 32'd8);
      step(20, 0, 0, 1, 1, 1, 0, 0, 2'b10, 2,  32'h0,        32'd0,         1, 1, 2,  32'h0BADCAFE, 32'd0);
      step(21, 1, 0, 1, 0, 0, 1, 0, 2'b10, 5,  32'hA5A5A5A5, 32'd4,         0, 0, 0,  32'h0,        32'd0);
      step(22, 0, 0, 1, 1, 1, 0, 0, 2'b10, 5,  32'h0,        32'd4,         1, 1, 5,  32'h55667788, 32'd4);
      repeat (3) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
